// File: rtl/riscv_csr_file.sv
// Machine-mode CSR file for the RV32 core. Handles CSR read/modify/write, trap entry and MRET,
// the 64-bit cycle/instret counters, interrupt pending/cause reporting and trap vector computation.
module riscv_csr_file #(
  parameter int          NUM_IRQ     = 16,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               csr_illegal,
  input  logic               trap_i,
  input  logic [31:0]        trap_cause_i,
  input  logic [31:0]        trap_pc_i,
  input  logic [31:0]        trap_val_i,
  input  logic               mret_i,
  input  logic               instret_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               irq_pending_o,
  output logic [31:0]        irq_cause_o,
  output logic [31:0]        trap_vector_o,
  output logic [31:0]        mepc_o
);

  localparam logic [31:0] MTVEC_INIT = {MTVEC_RESET[31:2], 1'b0, VECTORED_EN && MTVEC_RESET[0]};

  logic               mstatusMie_q, mstatusMie_d;
  logic               mstatusMpie_q, mstatusMpie_d;
  logic [NUM_IRQ-1:0] mie_q, mie_d;
  logic [NUM_IRQ-1:0] mip_q;
  logic [31:0]        mtvec_q, mtvec_d;
  logic [31:0]        mscratch_q, mscratch_d;
  logic [31:0]        mepc_q, mepc_d;
  logic [31:0]        mcause_q, mcause_d;
  logic [31:0]        mtval_q, mtval_d;
  logic [63:0]        mcycle_q, mcycle_d;
  logic [63:0]        minstret_q, minstret_d;

  logic [31:0]        mieFull, mipFull, mstatusFull;
  logic [31:0]        rdRaw, newVal;
  logic               implemented, readOnly, writeEn;
  logic [NUM_IRQ-1:0] pendEn;

  always_comb begin
    mieFull = '0;
    mipFull = '0;
    mieFull[16 +: NUM_IRQ] = mie_q;
    mipFull[16 +: NUM_IRQ] = mip_q;
    mstatusFull = {19'b0, 2'b11, 3'b0, mstatusMpie_q, 3'b0, mstatusMie_q, 3'b0};
  end

  // Address decode; the user-level counter aliases and mip are readable but never writable.
  always_comb begin
    implemented = 1'b1;
    readOnly    = 1'b0;
    rdRaw       = '0;
    case (csr_addr)
      12'h300: rdRaw = mstatusFull;
      12'h304: rdRaw = mieFull;
      12'h305: rdRaw = mtvec_q;
      12'h340: rdRaw = mscratch_q;
      12'h341: rdRaw = mepc_q;
      12'h342: rdRaw = mcause_q;
      12'h343: rdRaw = mtval_q;
      12'h344: begin rdRaw = mipFull; readOnly = 1'b1; end
      12'hB00: rdRaw = mcycle_q[31:0];
      12'hB80: rdRaw = mcycle_q[63:32];
      12'hB02: rdRaw = minstret_q[31:0];
      12'hB82: rdRaw = minstret_q[63:32];
      12'hC00: begin rdRaw = mcycle_q[31:0];    readOnly = 1'b1; end
      12'hC80: begin rdRaw = mcycle_q[63:32];   readOnly = 1'b1; end
      12'hC02: begin rdRaw = minstret_q[31:0];  readOnly = 1'b1; end
      12'hC82: begin rdRaw = minstret_q[63:32]; readOnly = 1'b1; end
      default: implemented = 1'b0;
    endcase
  end

  assign csr_illegal = (csr_op != 2'b00) && (!implemented || readOnly);
  assign csr_rdata   = csr_illegal ? 32'h0 : rdRaw;
  assign writeEn     = (csr_op != 2'b00) && !csr_illegal && !trap_i && !mret_i;

  always_comb begin
    case (csr_op)
      2'b01:   newVal = csr_wdata;
      2'b10:   newVal = rdRaw | csr_wdata;
      2'b11:   newVal = rdRaw & ~csr_wdata;
      default: newVal = rdRaw;
    endcase
  end

  // Trap beats MRET beats CSR write; a written counter half takes the new value instead of the increment.
  always_comb begin
    mstatusMie_d  = mstatusMie_q;
    mstatusMpie_d = mstatusMpie_q;
    mie_d         = mie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    mcycle_d      = mcycle_q + 64'd1;
    minstret_d    = minstret_q + {63'b0, instret_i};
    if (trap_i) begin
      mepc_d        = {trap_pc_i[31:2], 2'b00};
      mcause_d      = trap_cause_i;
      mtval_d       = trap_val_i;
      mstatusMpie_d = mstatusMie_q;
      mstatusMie_d  = 1'b0;
    end else if (mret_i) begin
      mstatusMie_d  = mstatusMpie_q;
      mstatusMpie_d = 1'b1;
    end else if (writeEn) begin
      case (csr_addr)
        12'h300: begin mstatusMie_d = newVal[3]; mstatusMpie_d = newVal[7]; end
        12'h304: mie_d               = newVal[16 +: NUM_IRQ];
        12'h305: mtvec_d             = {newVal[31:2], 1'b0, VECTORED_EN && newVal[0]};
        12'h340: mscratch_d          = newVal;
        12'h341: mepc_d              = {newVal[31:2], 2'b00};
        12'h342: mcause_d            = newVal;
        12'h343: mtval_d             = newVal;
        12'hB00: mcycle_d[31:0]      = newVal;
        12'hB80: mcycle_d[63:32]     = newVal;
        12'hB02: minstret_d[31:0]    = newVal;
        12'hB82: minstret_d[63:32]   = newVal;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatusMie_q  <= 1'b0;
      mstatusMpie_q <= 1'b0;
      mie_q         <= '0;
      mip_q         <= '0;
      mtvec_q       <= MTVEC_INIT;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      mcycle_q      <= '0;
      minstret_q    <= '0;
    end else begin
      mstatusMie_q  <= mstatusMie_d;
      mstatusMpie_q <= mstatusMpie_d;
      mie_q         <= mie_d;
      mip_q         <= irq_i;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      mcycle_q      <= mcycle_d;
      minstret_q    <= minstret_d;
    end
  end

  assign pendEn        = mip_q & mie_q;
  assign irq_pending_o = mstatusMie_q && (|pendEn);
  assign mepc_o        = mepc_q;

  // Walk from the top down so the lowest-index line wins.
  always_comb begin
    irq_cause_o = 32'h0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pendEn[i]) irq_cause_o = 32'h8000_0000 | 32'(16 + i);
    end
  end

  always_comb begin
    trap_vector_o = {mtvec_q[31:2], 2'b00};
    if (mtvec_q[0] && trap_cause_i[31]) begin
      trap_vector_o = {mtvec_q[31:2], 2'b00} + {trap_cause_i[29:0], 2'b00};
    end
  end

endmodule

// File: tb/tb_riscv_csr_file.sv
// Directed testbench for riscv_csr_file: a table of single-cycle CSR accesses with read-back,
// followed by hand-written sequences for interrupts, traps/MRET, counter carry and mid-run reset.
module tb_riscv_csr_file;

  logic        clk;
  logic        rst;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_i;
  logic [31:0] trap_cause_i;
  logic [31:0] trap_pc_i;
  logic [31:0] trap_val_i;
  logic        mret_i;
  logic        instret_i;
  logic [3:0]  irq_i;
  logic        irq_pending_o;
  logic [31:0] irq_cause_o;
  logic [31:0] trap_vector_o;
  logic [31:0] mepc_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        expIllegal;
    logic [11:0] chkAddr;
    logic [31:0] expRead;
  } vec_t;

  vec_t vecs[14];

  riscv_csr_file #(
    .NUM_IRQ(4),
    .MTVEC_RESET(32'h0000_0100),
    .VECTORED_EN(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .csr_op(csr_op),
    .csr_addr(csr_addr),
    .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal),
    .trap_i(trap_i),
    .trap_cause_i(trap_cause_i),
    .trap_pc_i(trap_pc_i),
    .trap_val_i(trap_val_i),
    .mret_i(mret_i),
    .instret_i(instret_i),
    .irq_i(irq_i),
    .irq_pending_o(irq_pending_o),
    .irq_cause_o(irq_cause_o),
    .trap_vector_o(trap_vector_o),
    .mepc_o(mepc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, actual, expected);
    end
  endtask

  // Combinational read with no operation in flight; takes 1 time unit.
  task automatic csrRead(input logic [11:0] addr, output logic [31:0] data);
    csr_op   = 2'b00;
    csr_addr = addr;
    #1;
    data = csr_rdata;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    logic [31:0] rd;
    @(negedge clk);
    csr_op    = v.op;
    csr_addr  = v.addr;
    csr_wdata = v.wdata;
    #1;
    checkOutput($sformatf("vec%0d_illegal", idx), {31'b0, csr_illegal}, {31'b0, v.expIllegal});
    if (v.expIllegal) checkOutput($sformatf("vec%0d_illegal_rdata", idx), csr_rdata, 32'h0);
    @(posedge clk);
    #1;
    csrRead(v.chkAddr, rd);
    checkOutput($sformatf("vec%0d_read", idx), rd, v.expRead);
  endtask

  initial begin
    logic [31:0] rd;

    vecs[0]  = '{2'b01, 12'h340, 32'h1234_5678, 1'b0, 12'h340, 32'h1234_5678};
    vecs[1]  = '{2'b10, 12'h340, 32'h0000_0001, 1'b0, 12'h340, 32'h1234_5679};
    vecs[2]  = '{2'b11, 12'h340, 32'h0000_0078, 1'b0, 12'h340, 32'h1234_5601};
    vecs[3]  = '{2'b01, 12'h304, 32'hFFFF_FFFF, 1'b0, 12'h304, 32'h000F_0000};
    vecs[4]  = '{2'b01, 12'h341, 32'h0000_1237, 1'b0, 12'h341, 32'h0000_1234};
    vecs[5]  = '{2'b01, 12'h305, 32'hFFFF_FFFF, 1'b0, 12'h305, 32'hFFFF_FFFD};
    vecs[6]  = '{2'b01, 12'h305, 32'h0000_0201, 1'b0, 12'h305, 32'h0000_0201};
    vecs[7]  = '{2'b01, 12'h7C0, 32'hFFFF_FFFF, 1'b1, 12'h340, 32'h1234_5601};
    vecs[8]  = '{2'b01, 12'hC00, 32'h0000_0000, 1'b1, 12'h340, 32'h1234_5601};
    vecs[9]  = '{2'b01, 12'h344, 32'hFFFF_FFFF, 1'b1, 12'h344, 32'h0000_0000};
    vecs[10] = '{2'b10, 12'h300, 32'h0000_0008, 1'b0, 12'h300, 32'h0000_1808};
    vecs[11] = '{2'b01, 12'h342, 32'h8000_000B, 1'b0, 12'h342, 32'h8000_000B};
    vecs[12] = '{2'b01, 12'h343, 32'hDEAD_BEEF, 1'b0, 12'h343, 32'hDEAD_BEEF};
    vecs[13] = '{2'b11, 12'hB02, 32'h0000_0000, 1'b0, 12'hB02, 32'h0000_0000};

    rst = 1'b1; csr_op = 2'b00; csr_addr = '0; csr_wdata = '0;
    trap_i = 1'b0; trap_cause_i = '0; trap_pc_i = '0; trap_val_i = '0;
    mret_i = 1'b0; instret_i = 1'b0; irq_i = '0;

    // Reset values, then free-running cycle counter
    repeat (2) @(negedge clk);
    rst = 1'b0;
    csrRead(12'h305, rd); checkOutput("reset_mtvec", rd, 32'h0000_0100);
    csrRead(12'hB00, rd); checkOutput("reset_mcycle", rd, 32'h0);
    checkOutput("reset_irq_pending", {31'b0, irq_pending_o}, 32'h0);
    checkOutput("reset_irq_cause", irq_cause_o, 32'h0);
    checkOutput("reset_mepc_o", mepc_o, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    csrRead(12'hB00, rd); checkOutput("mcycle_after5", rd, 32'd5);

    for (int i = 0; i < 14; i++) applyStimulus(i, vecs[i]);

    // Interrupt line 2 reaches irq_pending_o one cycle after it rises
    @(negedge clk);
    irq_i = 4'b0100;
    #1;
    checkOutput("irq_not_yet", {31'b0, irq_pending_o}, 32'h0);
    @(posedge clk); #1;
    checkOutput("irq_pending", {31'b0, irq_pending_o}, 32'h1);
    checkOutput("irq_cause", irq_cause_o, 32'h8000_0012);
    csrRead(12'h344, rd); checkOutput("mip_read", rd, 32'h0004_0000);

    // Trap with a colliding mscratch write
    @(negedge clk);
    trap_i = 1'b1; trap_cause_i = 32'h8000_0012; trap_pc_i = 32'h0000_1236; trap_val_i = 32'h0000_0055;
    csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'hAAAA_AAAA;
    #1;
    checkOutput("trap_vector_irq", trap_vector_o, 32'h0000_0248);
    @(posedge clk); #1;
    trap_i = 1'b0;
    checkOutput("trap_mepc_o", mepc_o, 32'h0000_1234);
    csrRead(12'h341, rd); checkOutput("trap_mepc", rd, 32'h0000_1234);
    csrRead(12'h300, rd); checkOutput("trap_mstatus", rd, 32'h0000_1880);
    csrRead(12'h342, rd); checkOutput("trap_mcause", rd, 32'h8000_0012);
    csrRead(12'h343, rd); checkOutput("trap_mtval", rd, 32'h0000_0055);
    csrRead(12'h340, rd); checkOutput("trap_mscratch_kept", rd, 32'h1234_5601);
    checkOutput("trap_irq_masked", {31'b0, irq_pending_o}, 32'h0);
    trap_cause_i = 32'h0000_0002;
    #1;
    checkOutput("trap_vector_exc", trap_vector_o, 32'h0000_0200);

    // MRET with a colliding mscratch write
    @(negedge clk);
    mret_i = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h5555_5555;
    @(posedge clk); #1;
    mret_i = 1'b0;
    csrRead(12'h300, rd); checkOutput("mret_mstatus", rd, 32'h0000_1888);
    csrRead(12'h340, rd); checkOutput("mret_mscratch_kept", rd, 32'h1234_5601);
    checkOutput("mret_irq_pending", {31'b0, irq_pending_o}, 32'h1);

    // Low-half write then high-half write, then carry into the high half
    @(negedge clk);
    csr_op = 2'b01; csr_addr = 12'hB00; csr_wdata = 32'hFFFF_FFFE;
    @(negedge clk);
    csr_op = 2'b01; csr_addr = 12'hB80; csr_wdata = 32'h0;
    @(posedge clk); #1;
    csrRead(12'hB00, rd); checkOutput("mcycle_pre_wrap", rd, 32'hFFFF_FFFF);
    csrRead(12'hB80, rd); checkOutput("mcycleh_pre_wrap", rd, 32'h0);
    @(posedge clk); #1;
    csrRead(12'hB00, rd); checkOutput("mcycle_wrap", rd, 32'h0);
    csrRead(12'hB80, rd); checkOutput("mcycleh_carry", rd, 32'h1);
    csrRead(12'hC80, rd); checkOutput("cycleh_alias", rd, 32'h1);

    // Retirement counting
    @(negedge clk);
    instret_i = 1'b1;
    repeat (3) @(negedge clk);
    instret_i = 1'b0;
    csrRead(12'hB02, rd); checkOutput("minstret_count", rd, 32'd3);
    csrRead(12'hC02, rd); checkOutput("instret_alias", rd, 32'd3);

    // Reset arriving mid-cycle aborts the pending write and clears state at once
    @(negedge clk);
    csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h0000_FFFF;
    #2;
    rst = 1'b1;
    #1;
    csrRead(12'hB00, rd); checkOutput("midreset_mcycle", rd, 32'h0);
    csrRead(12'h340, rd); checkOutput("midreset_mscratch", rd, 32'h0);
    csrRead(12'h305, rd); checkOutput("midreset_mtvec", rd, 32'h0000_0100);
    checkOutput("midreset_irq_pending", {31'b0, irq_pending_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    csrRead(12'h340, rd); checkOutput("postreset_mscratch", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
